// File: rtl/cache_pkg.sv
// cache_pkg: address field layout, tag-entry bit positions, FSM states and
// victim selection shared by the refill controller and its pLRU store.
package cache_pkg;
   localparam int ADDR_W   = 12;
   localparam int TAG_W    = 5;
   localparam int SET_W    = 3;
   localparam int BEAT_W   = 2;
   localparam int WAY_W    = 2;
   localparam int ENT_W    = 7;
   localparam int TAG_LSB  = 7;
   localparam int SET_LSB  = 4;
   localparam int ENT_V    = 6;
   localparam int ENT_D    = 5;
   localparam int BEATS    = 4;
   localparam int WAYS     = 4;
   typedef enum logic [2:0] {S_IDLE, S_WB, S_RD_REQ, S_RD_DATA, S_UPDATE} state_t;
   // Lowest-numbered invalid way wins; with every way valid the pLRU tree decides.
   function automatic logic [WAY_W-1:0] pick_victim(input logic [WAYS*ENT_W-1:0] ents,
                                                    input logic [2:0] plru);
      logic [WAY_W-1:0] v;
      v = plru[0] ? {1'b1, plru[2]} : {1'b0, plru[1]};
      for (int w = WAYS - 1; w >= 0; w--)
         if (!ents[ENT_W*w+ENT_V]) v = WAY_W'(w);
      return v;
   endfunction
endpackage

// File: rtl/cache_plru.sv
// cache_plru: per-set 3-bit tree pLRU state with one combinational read port
// and one update port.
module cache_plru
   import cache_pkg::*;
#(
   parameter int SETS = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [SET_W-1:0]        i_rd_set,
   output logic [2:0]              o_bits,
   input  logic                    i_upd,
   input  logic [SET_W-1:0]        i_upd_set,
   input  logic [WAY_W-1:0]        i_upd_way
);
   logic [2:0] r_bits [SETS];
   assign o_bits = r_bits[i_rd_set];
   // b0 points away from the touched half, b1/b2 away from the touched way in it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SETS; s++) r_bits[s] <= '0;
      end else if (i_upd) begin
         r_bits[i_upd_set][0] <= ~i_upd_way[1];
         if (i_upd_way[1]) r_bits[i_upd_set][2] <= ~i_upd_way[0];
         else r_bits[i_upd_set][1] <= ~i_upd_way[0];
      end
   end
endmodule

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: handles a lookup result -- pLRU touch on hits, victim
// write-back and line refill on misses -- then pulses done.
module cache_refill_ctrl
   import cache_pkg::*;
#(
   parameter int SETS = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [ADDR_W-1:0]       req_addr,
   input  logic                    req_write,
   input  logic                    req_hit,
   input  logic [WAY_W-1:0]        req_hit_way,
   input  logic [WAYS*ENT_W-1:0]   req_set_entries,
   output logic                    mem_rd_valid,
   input  logic                    mem_rd_ready,
   output logic [ADDR_W-1:0]       mem_rd_addr,
   input  logic                    mem_rdata_valid,
   input  logic [31:0]             mem_rdata,
   output logic                    mem_wr_valid,
   input  logic                    mem_wr_ready,
   output logic [ADDR_W-1:0]       mem_wr_addr,
   output logic [31:0]             mem_wr_data,
   output logic [SET_W-1:0]        arr_set,
   output logic [WAY_W-1:0]        arr_way,
   output logic [BEAT_W-1:0]       arr_beat,
   input  logic [31:0]             arr_rdata,
   output logic                    arr_we,
   output logic                    tag_we,
   output logic [ENT_W-1:0]        tag_wdata,
   output logic                    done
);
   state_t              r_state;
   logic [TAG_W-1:0]    r_tag, r_vtag;
   logic [SET_W-1:0]    r_set;
   logic [WAY_W-1:0]    r_way;
   logic [BEAT_W-1:0]   r_beat;
   logic                r_write, r_done, r_hit_we;
   logic [2:0]          w_plru;
   logic [WAY_W-1:0]    w_victim;
   logic [ENT_W-1:0]    w_vent;
   logic                w_last, w_upd;
   logic                w_unused;
   assign w_unused = ^{mem_rdata, req_addr[SET_LSB-1:0]};
   assign w_victim = pick_victim(req_set_entries, w_plru);
   assign w_vent   = req_set_entries[ENT_W*int'(w_victim) +: ENT_W];
   assign w_last   = r_beat == BEAT_W'(BEATS - 1);
   assign w_upd    = (r_state == S_IDLE && req_valid && req_hit) || r_state == S_UPDATE;
   cache_plru #(.SETS(SETS)) u_plru (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_rd_set  (req_addr[SET_LSB +: SET_W]),
      .o_bits    (w_plru),
      .i_upd     (w_upd),
      .i_upd_set (r_state == S_UPDATE ? r_set : req_addr[SET_LSB +: SET_W]),
      .i_upd_way (r_state == S_UPDATE ? r_way : req_hit_way)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_tag    <= '0;
         r_vtag   <= '0;
         r_set    <= '0;
         r_way    <= '0;
         r_beat   <= '0;
         r_write  <= 1'b0;
         r_done   <= 1'b0;
         r_hit_we <= 1'b0;
      end else begin
         r_done   <= 1'b0;
         r_hit_we <= 1'b0;
         case (r_state)
            S_IDLE: if (req_valid) begin
               r_tag   <= req_addr[TAG_LSB +: TAG_W];
               r_set   <= req_addr[SET_LSB +: SET_W];
               r_write <= req_write;
               r_beat  <= '0;
               if (req_hit) begin
                  r_way    <= req_hit_way;
                  r_done   <= 1'b1;
                  r_hit_we <= req_write;
               end else begin
                  r_way   <= w_victim;
                  r_vtag  <= w_vent[TAG_W-1:0];
                  r_state <= (w_vent[ENT_V] && w_vent[ENT_D]) ? S_WB : S_RD_REQ;
               end
            end
            S_WB: if (mem_wr_ready) begin
               r_beat <= r_beat + 1'b1;
               if (w_last) r_state <= S_RD_REQ;
            end
            S_RD_REQ: if (mem_rd_ready) r_state <= S_RD_DATA;
            S_RD_DATA: if (mem_rdata_valid) begin
               r_beat <= r_beat + 1'b1;
               if (w_last) r_state <= S_UPDATE;
            end
            S_UPDATE: begin
               r_state <= S_IDLE;
               r_done  <= 1'b1;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
   assign req_ready    = r_state == S_IDLE;
   assign mem_rd_valid = r_state == S_RD_REQ;
   assign mem_rd_addr  = mem_rd_valid ? {r_tag, r_set, 4'b0} : '0;
   assign mem_wr_valid = r_state == S_WB;
   assign mem_wr_addr  = mem_wr_valid ? {r_vtag, r_set, r_beat, 2'b0} : '0;
   assign mem_wr_data  = mem_wr_valid ? arr_rdata : '0;
   assign arr_set      = r_set;
   assign arr_way      = r_way;
   assign arr_beat     = r_beat;
   assign arr_we       = r_state == S_RD_DATA && mem_rdata_valid;
   // Store hits mark the line dirty in the cycle after acceptance, alongside done.
   assign tag_we       = r_hit_we || r_state == S_UPDATE;
   assign tag_wdata    = tag_we ? {1'b1, r_write, r_tag} : '0;
   assign done         = r_done;
endmodule

// File: doc/cache_refill_ctrl.md
CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl
Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-002 Parameter SETS, 8: number of sets, indexed by address [6:4].
REQ-003 Parameter BEATS, 4: 32-bit beats per 16-byte line, beat index from address [3:2].
REQ-004 clk  in  1  clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req_valid  in  1  lookup result presented.
REQ-007 req_ready  out  1  block accepts a lookup; high only in IDLE.
REQ-008 req_addr  in  12  access address; tag [11:7], set [6:4], offset [3:0].
REQ-009 req_write  in  1  access is a store.
REQ-010 req_hit  in  1  hit indication from the hit/miss stage.
REQ-011 req_hit_way  in  2  hitting way; valid when req_hit is high.
REQ-012 req_set_entries  in  28  four 7-bit tag entries of the set, way w at [7w+6:7w]; entry bit6 valid, bit5 dirty, [4:0] tag.
REQ-013 mem_rd_valid / mem_rd_ready  out / in  1 / 1  line-read request handshake.
REQ-014 mem_rd_addr  out  12  line-aligned read address {tag, set, 4'b0}.
REQ-015 mem_rdata_valid  in  1  one read beat present this cycle.
REQ-016 mem_rdata  in  32  read beat; the datapath writes it into the data array directly.
REQ-017 mem_wr_valid / mem_wr_ready  out / in  1 / 1  write-back beat handshake.
REQ-018 mem_wr_addr  out  12  write-back beat address {victim tag, set, beat, 2'b0}.
REQ-019 mem_wr_data  out  32  write-back beat, equal to arr_rdata.
REQ-020 arr_set / arr_way / arr_beat  out  3 / 2 / 2  data- and tag-array index.
REQ-021 arr_rdata  in  32  data-array word at the index, returned combinationally.
REQ-022 arr_we  out  1  write mem_rdata into the data array at the index.
REQ-023 tag_we / tag_wdata  out / out  1 / 7  write the tag entry at arr_set/arr_way.
REQ-024 done  out  1  one-cycle pulse when the access completes.
Function
REQ-025 The FSM SHALL have the states IDLE, WB, RD_REQ, RD_DATA and UPDATE.
REQ-026 On a hit accepted in IDLE:
- the pLRU of the set SHALL be updated, with no memory traffic;
- if req_write is high, tag_we SHALL pulse with dirty set;
- done SHALL pulse in the next cycle (latency 1).
REQ-027 On a miss, the victim SHALL be the lowest-numbered way whose valid bit is 0; with no invalid way, the victim SHALL be the pLRU choice.
REQ-028 pLRU SHALL keep 3 bits per set (b0, b1, b2):
- victim selection: b0=0 selects way {0,b1}; b0=1 selects way {1,b2};
- on an access to way w: b0 SHALL become ~w[1]; if w[1]=0, b1 SHALL become ~w[0], else b2 SHALL become ~w[0].
REQ-029 Victim valid and dirty: the next state SHALL be WB, which sends 4 beats (beat 0..3) with one beat per mem_wr handshake; the beat index SHALL wrap only within the line. Otherwise the next state SHALL be RD_REQ.
REQ-030 RD_REQ SHALL hold mem_rd_valid high until mem_rd_ready, then enter RD_DATA.
REQ-031 RD_DATA SHALL assert arr_we for each mem_rdata_valid beat 0..3, then enter UPDATE.
REQ-032 UPDATE SHALL write tag_wdata = {1, req_write, tag}, update the pLRU, and pulse done in the following IDLE cycle.
REQ-033 The miss-path latency SHALL be 2 + write-back handshakes + 1 + beat arrivals.
REQ-034 Input qualification:
- mem_rdata_valid outside RD_DATA SHALL be ignored;
- req_valid outside IDLE SHALL be ignored;
- the request SHALL be latched on acceptance, so later input changes have no effect.
REQ-035 Simultaneous hit and invalid way: the hit SHALL win and no fill SHALL occur.
Reset
REQ-036 Reset, including mid-operation, SHALL force:
- state IDLE, with all pLRU bits 0;
- req_ready 1;
- all valid/we/done outputs 0, and address/data outputs 0;
- any outstanding memory transaction abandoned.
Structure
REQ-037 Package cache_pkg SHALL hold the address field widths, the tag-entry bit positions, the state enum and BEATS; the pLRU storage SHALL be the sub-module cache_plru.
Verification
REQ-038 Read hit: addr 0x2A4 (set 2), req_hit=1, way 3 -> done next cycle, no mem_* valid, set 2 pLRU b0=0, b2=0.
REQ-039 Miss with way 1 invalid: addr 0x150 -> mem_rd_addr 0x150, 4 arr_we at way 1, tag_wdata 7'b1000010, done.
REQ-040 Dirty eviction: all ways valid, pLRU victim way 0 entry 7'b1100011, addr 0x530 -> 4 writes at 0x1B0..0x1BC, then read 0x530.
REQ-041 Store miss -> final tag_wdata bit5 = 1; mem_rd_ready held low 5 cycles -> mem_rd_valid stays high and stable.
REQ-042 rst_n low during RD_DATA beat 2 -> outputs at reset values immediately; a later request fills cleanly.
